siphash_msg_sequencer: RTL
==========================

Name: siphash_msg_sequencer

Overview:
- Controls one siphash_core instance: turns a stream of 64-bit message words plus a 128-bit key into one SipHash digest.
- Derives the core's 256-bit initial state from the key.
- Issues the initalize / compress / finalize pulses and builds the length-padded final block.
- Holds the digest until the consumer accepts it; sits between the host message interface and the core.

Parameters:
DEF_COMP_ROUNDS, 2, compression rounds used when compression_rounds is latched as 0
DEF_FINAL_ROUNDS, 4, finalization rounds used when final_rounds is latched as 0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin new hash; sampled only in IDLE
key  in  128  k0=key[63:0], k1=key[127:64]; sampled with start
compression_rounds  in  4  c; sampled with start
final_rounds  in  4  d; sampled with start
s_data  in  64  message word, little-endian (byte i = bits 8i+7:8i)
s_valid  in  1  word valid
s_ready  out  1  word accepted when s_valid&s_ready
s_last  in  1  final word of message
s_bytes  in  4  valid bytes in word: 8 if !s_last; 0..8 if s_last
digest  out  64  hash result
digest_valid  out  1  digest held valid
digest_ready  in  1  consumer accepts digest
busy  out  1  high in every state except IDLE
core_initalize  out  1  one-cycle pulse to core
core_compress  out  1  one-cycle pulse to core
core_finalize  out  1  one-cycle pulse to core
core_compression_rounds  out  4  latched c
core_final_rounds  out  4  latched d
core_key  out  256  {k1^7465646279746573, k0^6c7967656e657261, k1^646f72616e646f6d, k0^736f6d6570736575}; MSB to LSB = v3,v2,v1,v0
core_nonce  out  64  block to compress (s_data or pad block)
core_ready  in  1  core idle
core_word  in  64  core result
core_word_valid  in  1  core result valid

Behaviour:
- Reset (sync, any state incl. mid-hash): state=IDLE; s_ready=0, digest=0, digest_valid=0, busy=0, all core pulses 0, byte counter 0, latched key/rounds 0. The core gets its own reset from the top (reset_n = ~reset). The sequencer never relies on core state across reset.
- States: IDLE, INIT, WAIT_WORD, COMP_ISSUE, COMP_WAIT, PAD_ISSUE, PAD_WAIT, FIN_ISSUE, FIN_WAIT, OUT.
- IDLE: start=1 -> latch key, c, d (value 0 replaced by DEF_*), clear len_cnt -> INIT. start ignored in all other states.
- INIT: core_initalize=1 for exactly one cycle -> WAIT_WORD. The core does not drop ready on init.
- WAIT_WORD: s_ready=1 only here and only while core_ready=1. On a handshake: latch word/last/bytes; len_cnt += bytes (8-bit, wraps mod 256).
  - !last -> COMP_ISSUE.
  - last & bytes==8 -> COMP_ISSUE, then the pad path.
  - last & bytes<8 -> PAD_ISSUE (tail bytes merged into the pad block).
- COMP_ISSUE: core_compress=1 one cycle, core_nonce=word -> COMP_WAIT.
- COMP_WAIT: the cycle after issue is always waited (core_ready drops one cycle late). After that, exit on core_ready=1:
  - pending last (bytes==8) -> PAD_ISSUE.
  - otherwise -> WAIT_WORD.
- Pad block: bits[63:56]=len_cnt; bits[8i+7:8i] = latched word byte i for i<bytes; all other bytes 0. With bytes==8 or 0, the block is {len_cnt,56'h0}.
- PAD_ISSUE: core_compress=1 with core_nonce=pad block -> PAD_WAIT (same wait rule) -> FIN_ISSUE.
- FIN_ISSUE: core_finalize=1 one cycle -> FIN_WAIT.
- FIN_WAIT: on core_word_valid=1 and core_ready=1, digest<=core_word, digest_valid<=1 -> OUT.
- OUT: hold digest/digest_valid until digest_ready=1. In that cycle digest_valid<=0 -> IDLE. digest keeps its value until the next result.
- core_nonce is combinational: pad block in PAD_ISSUE, latched word otherwise. It must be stable in the pulse cycle.
- Exactly one core pulse per cycle at most; pulses are never issued while core_ready=0.
- len_cnt counts true bytes only; only the low 8 bits are kept, per SipHash.
- s_bytes>8, or s_bytes!=8 without s_last: undefined input. The treatment must not hang the FSM: treat as 8.

Test Plan:
- Key 000102..0f (k0=0706050403020100, k1=0f0e0d0c0b0a0908), c/d=2/4, single word s_last=1, s_bytes=0 -> one compress with nonce 0000000000000000, finalize, digest=726fdb47dd0e0e31.
- Same key, 15-byte message 00..0e as word0=0706050403020100 (bytes=8), word1=000e0d0c0b0a0908 (last, bytes=7) -> pad nonce 0f0e0d0c0b0a0908, digest=a129ca6149be45e5.
- Same key, 8-byte message 0706050403020100 sent with last, bytes=8 -> two compresses (second nonce 0800000000000000), digest=93f5f5799a932462.
- Backpressure: s_valid low for random gaps and digest_ready held low 20 cycles -> digest_valid stays 1, digest stable, no extra core pulses, s_ready=0 throughout.
- Rounds 0/0 at start -> core_compression_rounds=2, core_final_rounds=4. Also c=1,d=3 -> rounds forwarded unchanged, and each COMP_WAIT lasts core's round count+1 cycles.
- Reset asserted in COMP_WAIT of a 3-word message -> next cycle IDLE, busy=0, s_ready=0, digest_valid=0. A following start plus the empty-message vector yields 726fdb47dd0e0e31.

Source files
------------

// File: rtl/siphash_msg_sequencer_if.sv
// Host-side bundle for siphash_msg_sequencer.
// Carries the start/key/rounds request, the 64-bit message word stream
// and the digest return path.
//   master : host side (drives start, key, rounds, s_*, digest_ready)
//   slave  : sequencer side (drives s_ready, digest, digest_valid, busy)
interface siphash_msg_sequencer_if;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned RND_W   = 4;
  localparam int unsigned BYTES_W = 4;

  logic                start;
  logic [KEY_W-1:0]    key;
  logic [RND_W-1:0]    compression_rounds;
  logic [RND_W-1:0]    final_rounds;

  logic [WORD_W-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;
  logic                s_last;
  logic [BYTES_W-1:0]  s_bytes;

  logic [WORD_W-1:0]   digest;
  logic                digest_valid;
  logic                digest_ready;
  logic                busy;

  modport master (
    output start, key, compression_rounds, final_rounds,
    output s_data, s_valid, s_last, s_bytes,
    output digest_ready,
    input  s_ready, digest, digest_valid, busy
  );

  modport slave (
    input  start, key, compression_rounds, final_rounds,
    input  s_data, s_valid, s_last, s_bytes,
    input  digest_ready,
    output s_ready, digest, digest_valid, busy
  );
endinterface

// File: rtl/siphash_msg_sequencer.sv
// SipHash message sequencer: drives one siphash_core from a stream of
// 64-bit little-endian message words and a 128-bit key, builds the
// length-padded final block and holds the digest until accepted.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   host (slave)      : start/key/rounds, s_* word stream, digest return, busy
//   core_initalize    : one-cycle init pulse to the core
//   core_compress     : one-cycle compress pulse (block on core_nonce)
//   core_finalize     : one-cycle finalize pulse
//   core_*_rounds     : latched c / d (0 replaced by defaults)
//   core_key          : initial v3..v0 derived from the latched key
//   core_nonce        : block to compress (latched word or pad block)
//   core_ready        : core idle
//   core_word(_valid) : core result
module siphash_msg_sequencer #(
  parameter int unsigned DEF_COMP_ROUNDS  = 2,
  parameter int unsigned DEF_FINAL_ROUNDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  siphash_msg_sequencer_if.slave host,
  output logic                   core_initalize,
  output logic                   core_compress,
  output logic                   core_finalize,
  output logic [3:0]             core_compression_rounds,
  output logic [3:0]             core_final_rounds,
  output logic [255:0]           core_key,
  output logic [63:0]            core_nonce,
  input  logic                   core_ready,
  input  logic [63:0]            core_word,
  input  logic                   core_word_valid
);

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned RND_W   = 4;
  localparam int unsigned BYTES_W = 4;
  localparam int unsigned LEN_W   = 8;

  // SipHash initialisation constants ("somepseudorandomlygeneratedbytes")
  localparam logic [WORD_W-1:0] IV0 = 64'h736f6d6570736575;
  localparam logic [WORD_W-1:0] IV1 = 64'h646f72616e646f6d;
  localparam logic [WORD_W-1:0] IV2 = 64'h6c7967656e657261;
  localparam logic [WORD_W-1:0] IV3 = 64'h7465646279746573;

  localparam logic [BYTES_W-1:0] FULL_BYTES = 4'd8;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    WAIT_WORD,
    COMP_ISSUE,
    COMP_WAIT,
    PAD_ISSUE,
    PAD_WAIT,
    FIN_ISSUE,
    FIN_WAIT,
    OUT
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [KEY_W-1:0]     key_q;
  logic [RND_W-1:0]     c_q;
  logic [RND_W-1:0]     d_q;
  logic [WORD_W-1:0]    word_q;
  logic                 last_q;
  logic [BYTES_W-1:0]   bytes_q;
  logic [LEN_W-1:0]     len_cnt;
  logic                 wait_armed;
  logic [WORD_W-1:0]    digest_q;
  logic                 digest_valid_q;
  logic                 busy_q;

  logic                 s_ready_int;
  logic                 word_fire;
  logic [BYTES_W-1:0]   in_bytes;
  logic [WORD_W-1:0]    pad_block;

  // Undefined byte counts (non-last word, or more than 8) count as a full word
  always_comb begin : in_bytes_sanitize
    in_bytes = FULL_BYTES;
    if (host.s_last && (host.s_bytes <= FULL_BYTES)) begin
      in_bytes = host.s_bytes;
    end
  end

  assign word_fire = s_ready_int && host.s_valid;

  // State register
  always_ff @(posedge clk) begin : fsm_state
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and core pulse decode
  always_comb begin : fsm_next
    state_next     = state;
    s_ready_int    = 1'b0;
    core_initalize = 1'b0;
    core_compress  = 1'b0;
    core_finalize  = 1'b0;
    case (state)
      IDLE: begin
        if (host.start) begin
          state_next = INIT;
        end
      end
      INIT: begin
        // Hold the pulse back rather than hit a core that is not idle
        if (core_ready) begin
          core_initalize = 1'b1;
          state_next     = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        s_ready_int = core_ready;
        if (core_ready && host.s_valid) begin
          if (host.s_last && (in_bytes < FULL_BYTES)) begin
            state_next = PAD_ISSUE;
          end else begin
            state_next = COMP_ISSUE;
          end
        end
      end
      COMP_ISSUE: begin
        core_compress = 1'b1;
        state_next    = COMP_WAIT;
      end
      COMP_WAIT: begin
        // First wait cycle is skipped: core_ready falls one cycle after the pulse
        if (wait_armed && core_ready) begin
          state_next = last_q ? PAD_ISSUE : WAIT_WORD;
        end
      end
      PAD_ISSUE: begin
        core_compress = 1'b1;
        state_next    = PAD_WAIT;
      end
      PAD_WAIT: begin
        if (wait_armed && core_ready) begin
          state_next = FIN_ISSUE;
        end
      end
      FIN_ISSUE: begin
        core_finalize = 1'b1;
        state_next    = FIN_WAIT;
      end
      FIN_WAIT: begin
        if (core_word_valid && core_ready) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (host.digest_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, word capture, length count and digest holding
  always_ff @(posedge clk) begin : datapath
    if (reset) begin
      key_q          <= '0;
      c_q            <= '0;
      d_q            <= '0;
      word_q         <= '0;
      last_q         <= 1'b0;
      bytes_q        <= '0;
      len_cnt        <= '0;
      wait_armed     <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // Low on the first cycle of any state, high while the state persists
      wait_armed <= (state_next == state);
      busy_q     <= (state_next != IDLE);

      if ((state == IDLE) && host.start) begin
        key_q   <= host.key;
        c_q     <= (host.compression_rounds == '0) ? RND_W'(DEF_COMP_ROUNDS)
                                                   : host.compression_rounds;
        d_q     <= (host.final_rounds == '0) ? RND_W'(DEF_FINAL_ROUNDS)
                                             : host.final_rounds;
        len_cnt <= '0;
        last_q  <= 1'b0;
      end

      if (word_fire) begin
        word_q  <= host.s_data;
        last_q  <= host.s_last;
        bytes_q <= in_bytes;
        len_cnt <= len_cnt + LEN_W'(in_bytes);
      end

      if ((state == FIN_WAIT) && core_word_valid && core_ready) begin
        digest_q       <= core_word;
        digest_valid_q <= 1'b1;
      end else if ((state == OUT) && host.digest_ready) begin
        digest_valid_q <= 1'b0;
      end
    end
  end

  // Final block: tail bytes of a short last word, message length in the top byte
  always_comb begin : pad_build
    pad_block = '0;
    for (int i = 0; i < 7; i++) begin
      if ((bytes_q < FULL_BYTES) && (BYTES_W'(i) < bytes_q)) begin
        pad_block[8*i +: 8] = word_q[8*i +: 8];
      end
    end
    pad_block[63:56] = len_cnt;
  end

  assign core_nonce = (state == PAD_ISSUE) ? pad_block : word_q;

  assign core_key = {key_q[127:64] ^ IV3,
                     key_q[63:0]   ^ IV2,
                     key_q[127:64] ^ IV1,
                     key_q[63:0]   ^ IV0};

  assign core_compression_rounds = c_q;
  assign core_final_rounds       = d_q;

  assign host.s_ready      = s_ready_int;
  assign host.digest       = digest_q;
  assign host.digest_valid = digest_valid_q;
  assign host.busy         = busy_q;

endmodule
